// File: rtl/vend_ctrl_fsm.sv
// Vending-transaction controller: select -> coin -> pay -> dispense/charge.
// Feeds the LCD display stage with status flags, the selected product
// number and the running coin sum. Every output comes from a register.
module vend_ctrl_fsm #(
    parameter int PRODUCT_NUM = 8,
    parameter int PRICE_STEP  = 5,
    parameter int MAX_SUM     = 999,
    parameter int HOLD_CYCLES = 150_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_sel,
    input  logic        key_pay,
    input  logic        key_cancel,
    input  logic        coin_1,
    input  logic        coin_5,
    input  logic        coin_10,
    output logic [3:0]  product_number,
    output logic [10:0] coin_val_sum,
    output logic        if_coin_flag,
    output logic        if_pay_flag,
    output logic        if_charge_flag,
    output logic        nonenough_flag,
    output logic        coin_ov_flag,
    output logic        dispense_pulse
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEL, COIN, PAY, CHARGE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        prod_q, prod_d;
    logic [10:0]       sum_q, sum_d;
    logic              ne_q, ne_d;
    logic              ov_q, ov_d;
    logic              disp_q, disp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0]        inc;
    logic              any_coin;
    logic [11:0]       sum_plus;
    logic              coin_ok;
    logic [10:0]       price;
    logic              hold_done;
    logic [3:0]        prod_next;

    // Coin increment of this cycle; simultaneous coins add up (max 16).
    assign inc       = {4'd0, coin_1} + (coin_5 ? 5'd5 : 5'd0) + (coin_10 ? 5'd10 : 5'd0);
    assign any_coin  = coin_1 | coin_5 | coin_10;
    // One extra bit so the overflow compare cannot wrap.
    assign sum_plus  = {1'b0, sum_q} + {7'd0, inc};
    assign coin_ok   = (sum_plus <= 12'(MAX_SUM));
    assign price     = 11'(int'(prod_q) * PRICE_STEP);
    assign hold_done = (cnt_q == CNT_LAST);
    assign prod_next = (prod_q == 4'(PRODUCT_NUM)) ? 4'd1 : prod_q + 4'd1;

    // State and output registers; async reset clears everything.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            prod_q  <= '0;
            sum_q   <= '0;
            ne_q    <= 1'b0;
            ov_q    <= 1'b0;
            disp_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            sum_q   <= sum_d;
            ne_q    <= ne_d;
            ov_q    <= ov_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and next output values; priority cancel > pay > coins > sel.
    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        sum_d   = sum_q;
        ne_d    = ne_q;
        ov_d    = ov_q;
        disp_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (key_sel) begin
                    state_d = SEL;
                    prod_d  = 4'd1;
                end
            end
            SEL: begin
                if (key_cancel) begin
                    state_d = IDLE;
                    prod_d  = '0;
                    ne_d    = 1'b0;
                    ov_d    = 1'b0;
                end else if (key_pay) begin
                    // Nothing has been inserted yet in SEL.
                    ne_d = 1'b1;
                end else if (any_coin) begin
                    state_d = COIN;
                    if (coin_ok) begin
                        sum_d = sum_plus[10:0];
                        ov_d  = 1'b0;
                        ne_d  = 1'b0;
                    end else begin
                        ov_d = 1'b1;
                    end
                end else if (key_sel) begin
                    prod_d = prod_next;
                end
            end
            COIN: begin
                if (key_cancel) begin
                    // Sum stays as-is: it is shown as the refund.
                    state_d = CHARGE;
                    prod_d  = '0;
                    ne_d    = 1'b0;
                    ov_d    = 1'b0;
                    cnt_d   = '0;
                end else if (key_pay) begin
                    if (sum_q >= price) begin
                        state_d = PAY;
                        disp_d  = 1'b1;
                        ne_d    = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        ne_d = 1'b1;
                    end
                end else if (any_coin) begin
                    if (coin_ok) begin
                        sum_d = sum_plus[10:0];
                        ov_d  = 1'b0;
                        ne_d  = 1'b0;
                    end else begin
                        ov_d = 1'b1;
                    end
                end
            end
            PAY: begin
                if (hold_done) begin
                    // Safe: PAY is entered only with sum >= price.
                    state_d = CHARGE;
                    sum_d   = sum_q - price;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHARGE: begin
                if (hold_done) begin
                    state_d = IDLE;
                    sum_d   = '0;
                    prod_d  = '0;
                    ne_d    = 1'b0;
                    ov_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign product_number = prod_q;
    assign coin_val_sum   = sum_q;
    assign if_coin_flag   = (state_q == SEL) || (state_q == COIN);
    assign if_pay_flag    = (state_q == PAY);
    assign if_charge_flag = (state_q == CHARGE);
    assign nonenough_flag = ne_q;
    assign coin_ov_flag   = ov_q;
    assign dispense_pulse = disp_q;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Scoreboard bench for vend_ctrl_fsm (HOLD_CYCLES=10, MAX_SUM=20).
module tb_vend_ctrl_fsm;

    localparam int HOLD = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_sel = 1'b0, key_pay = 1'b0, key_cancel = 1'b0;
    logic        coin_1 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0;
    logic [3:0]  product_number;
    logic [10:0] coin_val_sum;
    logic        if_coin_flag, if_pay_flag, if_charge_flag;
    logic        nonenough_flag, coin_ov_flag, dispense_pulse;

    typedef struct packed {
        logic [3:0]  pn;
        logic [10:0] sum;
        logic        fc, fp, fch, ne, ov, dp;
    } obs_t;

    obs_t exp_q[$];
    obs_t act_q[$];
    int   total = 0;
    int   bad   = 0;

    vend_ctrl_fsm #(.PRODUCT_NUM(8), .PRICE_STEP(5), .MAX_SUM(20), .HOLD_CYCLES(HOLD)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .key_sel(key_sel), .key_pay(key_pay), .key_cancel(key_cancel),
        .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
        .product_number(product_number), .coin_val_sum(coin_val_sum),
        .if_coin_flag(if_coin_flag), .if_pay_flag(if_pay_flag),
        .if_charge_flag(if_charge_flag), .nonenough_flag(nonenough_flag),
        .coin_ov_flag(coin_ov_flag), .dispense_pulse(dispense_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic obs_t cur();
        return '{product_number, coin_val_sum, if_coin_flag, if_pay_flag,
                 if_charge_flag, nonenough_flag, coin_ov_flag, dispense_pulse};
    endfunction

    function automatic obs_t mk(int pn, int sum, bit fc, bit fp, bit fch, bit ne, bit ov, bit dp);
        return '{4'(pn), 11'(sum), fc, fp, fch, ne, ov, dp};
    endfunction

    // Drive one cycle of pulses, then record what the DUT shows after the edge.
    task automatic cyc(bit s, bit p, bit c, bit c1, bit c5, bit c10);
        key_sel = s; key_pay = p; key_cancel = c;
        coin_1 = c1; coin_5 = c5; coin_10 = c10;
        @(posedge sys_clk); #1;
        key_sel = 0; key_pay = 0; key_cancel = 0;
        coin_1 = 0; coin_5 = 0; coin_10 = 0;
        act_q.push_back(cur());
    endtask

    task automatic idle_n(int n, obs_t e);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        obs_t o, e;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        act_q.push_back(cur());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL reset got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_purchase();
        obs_t o, e;
        int k = 0;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(2, 10, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 0, 1);
        exp_q.push_back(mk(2, 15, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 1, 0);
        exp_q.push_back(mk(2, 15, 0, 1, 0, 0, 0, 1)); cyc(0, 1, 0, 0, 0, 0);
        idle_n(HOLD - 1, mk(2, 15, 0, 1, 0, 0, 0, 0));
        idle_n(HOLD, mk(2, 5, 0, 0, 1, 0, 0, 0));
        idle_n(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL purchase#%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_nonenough();
        obs_t o, e;
        int k = 0;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 10, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 0, 1);
        exp_q.push_back(mk(3, 10, 1, 0, 0, 1, 0, 0)); cyc(0, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(3, 10, 1, 0, 0, 1, 0, 0)); cyc(1, 0, 0, 0, 0, 0); // product locked
        exp_q.push_back(mk(3, 15, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 1, 0);
        exp_q.push_back(mk(3, 15, 0, 1, 0, 0, 0, 1)); cyc(0, 1, 0, 0, 0, 0);
        idle_n(HOLD - 1, mk(3, 15, 0, 1, 0, 0, 0, 0));
        idle_n(HOLD, mk(3, 0, 0, 0, 1, 0, 0, 0));
        idle_n(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL nonenough#%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_overflow();
        obs_t o, e;
        int k = 0;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 0, 1);
        exp_q.push_back(mk(1, 20, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 0, 1);
        exp_q.push_back(mk(1, 20, 1, 0, 0, 0, 1, 0)); cyc(0, 0, 0, 1, 0, 0);
        exp_q.push_back(mk(1, 20, 1, 0, 0, 0, 1, 0)); cyc(0, 0, 0, 1, 1, 0);
        exp_q.push_back(mk(0, 20, 0, 0, 1, 0, 0, 0)); cyc(0, 0, 1, 0, 0, 0);
        idle_n(HOLD - 1, mk(0, 20, 0, 0, 1, 0, 0, 0));
        idle_n(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL overflow#%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_cancel();
        obs_t o, e;
        int k = 0;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0)); cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 1, 0);
        exp_q.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 1, 0, 0);
        exp_q.push_back(mk(0, 6, 0, 0, 1, 0, 0, 0)); cyc(0, 0, 1, 0, 0, 0);
        idle_n(HOLD - 1, mk(0, 6, 0, 0, 1, 0, 0, 0));
        idle_n(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL cancel#%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_wrap_priority();
        obs_t o, e;
        int k = 0;
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(mk((i > 8) ? 1 : i, 0, 1, 0, 0, 0, 0, 0));
            cyc(1, 0, 0, 0, 0, 0);
        end
        exp_q.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0)); cyc(0, 1, 0, 0, 0, 0); // pay with nothing in
        exp_q.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0)); cyc(1, 0, 0, 0, 1, 0); // coin beats sel
        exp_q.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0)); cyc(0, 1, 1, 0, 0, 0); // cancel beats pay
        idle_n(HOLD - 1, mk(0, 5, 0, 0, 1, 0, 0, 0));
        idle_n(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL wrap_prio#%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_reset_mid_pay();
        obs_t o, e;
        int k = 0;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));  cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 0, 1);
        exp_q.push_back(mk(1, 10, 0, 1, 0, 0, 0, 1)); cyc(0, 1, 0, 0, 0, 0);
        idle_n(3, mk(1, 10, 0, 1, 0, 0, 0, 0));
        // Mid-cycle assert: outputs must drop with no clock edge in between.
        #1 sys_rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        act_q.push_back(cur());
        @(negedge sys_clk); sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); cyc(0, 0, 0, 0, 0, 1); // coin ignored
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); cyc(0, 1, 1, 1, 1, 0);
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0)); cyc(1, 0, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); cyc(0, 0, 1, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL rst_mid_pay#%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_nonenough();
        test_overflow();
        test_cancel();
        test_wrap_priority();
        test_reset_mid_pay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
